// File: rtl/mpf_vtp_pkg.sv
// Shared CCI-P channel types and error-response descriptors for the VTP translation
// error responder.
package mpf_vtp_pkg;

  typedef enum logic [1:0] {eVC_VA, eVC_VL0, eVC_VH0, eVC_VH1} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;

  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4, eREQ_INTR     = 4'h6
  } t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    t_ccip_mdata mdata;
    t_ccip_clLen cl_len;
    t_ccip_vc    vc_sel;
  } t_mpf_vtp_err_rsp_c0_entry;

  typedef struct packed {
    t_ccip_mdata mdata;
    t_ccip_clLen cl_len;
    t_ccip_vc    vc_sel;
  } t_mpf_vtp_err_rsp_c1_entry;

  typedef enum logic {ERR_RSP_IDLE, ERR_RSP_BURST} t_mpf_vtp_err_rsp_state;

  localparam logic [511:0] MPF_VTP_ERR_POISON_DATA = {16{32'hDEAD_BEEF}};

  function automatic logic isReadReq(input t_ccip_c0_req req);
    return (req == eREQ_RDLINE_I) || (req == eREQ_RDLINE_S);
  endfunction

  function automatic logic isWriteReq(input t_ccip_c1_req req);
    return (req == eREQ_WRLINE_I) || (req == eREQ_WRLINE_M) || (req == eREQ_WRPUSH_I);
  endfunction

endpackage

// File: rtl/mpf_vtp_err_rsp_fifo.sv
// Small descriptor FIFO for failed-translation requests. Power-of-2 depth, entries
// reset asynchronously, almostFull asserts when free slots <= ALMFULL_SLOTS.
module mpf_vtp_err_rsp_fifo #(
  parameter type T             = logic,
  parameter int  DEPTH         = 16,
  parameter int  ALMFULL_SLOTS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  T     enq_data,
  input  logic enq_en,
  input  logic deq_en,
  output T     first,
  output logic notEmpty,
  output logic full,
  output logic almostFull
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ALM_W   = (AW + 1)'(ALMFULL_SLOTS);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_en) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq_en) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_en, deq_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign first      = mem[rd_ptr];
  assign notEmpty   = (count != '0);
  assign full       = (count == DEPTH_W);
  assign almostFull = ((DEPTH_W - count) <= ALM_W);

endmodule

// File: rtl/mpf_vtp_ccip_xlate_err_rsp.sv
// Drops Tx requests whose VTP translation failed and injects poison/ack responses on Rx
// so AFU tags still retire. Optional MPF_VTP_ERR_RSP_STATS_EN adds enqueue counters.
module mpf_vtp_ccip_xlate_err_rsp
  import mpf_vtp_pkg::*;
#(
  parameter int ERR_FIFO_DEPTH    = 16,
  parameter int ERR_ALMFULL_SLOTS = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_if_ccip_c0_Tx c0_tx_in,
  input  logic           error_c0,
  input  t_if_ccip_c1_Tx c1_tx_in,
  input  logic           error_c1,
  output t_if_ccip_c0_Tx c0_tx_out,
  output t_if_ccip_c1_Tx c1_tx_out,
  input  t_if_ccip_c0_Rx c0_rx_in,
  input  t_if_ccip_c1_Rx c1_rx_in,
  output t_if_ccip_c0_Rx c0_rx_out,
  output t_if_ccip_c1_Rx c1_rx_out,
  output logic           err_rsp_c0,
  output logic           err_rsp_c1,
  output logic           err_almostFull,
  output logic           err_overflow
`ifdef MPF_VTP_ERR_RSP_STATS_EN
  ,
  output logic [31:0]    stat_err_c0,
  output logic [31:0]    stat_err_c1
`endif
);

  t_mpf_vtp_err_rsp_c0_entry c0_enq_entry, c0_head;
  t_mpf_vtp_err_rsp_c1_entry c1_enq_entry, c1_head;
  logic c0_enq_req, c0_enq_en, c0_deq, c0_not_empty, c0_full, c0_almfull;
  logic c1_enq_req, c1_enq_en, c1_deq, c1_not_empty, c1_full, c1_almfull;
  logic c0_slot_free, c1_slot_free, c0_inj_fire, c1_inj_fire, c0_last;
  t_mpf_vtp_err_rsp_state c0_state, c0_state_nxt;
  logic [1:0] c0_beat, c0_beat_nxt;
  t_if_ccip_c0_Rx c0_inj_rsp;
  t_if_ccip_c1_Rx c1_inj_rsp;

  always_comb begin
    c0_tx_out       = c0_tx_in;
    c0_tx_out.valid = c0_tx_in.valid & ~error_c0;
    c1_tx_out       = c1_tx_in;
    c1_tx_out.valid = c1_tx_in.valid & ~error_c1;
  end

  // Only the sop beat of a failed write carries a tag that needs a response.
  assign c0_enq_req = c0_tx_in.valid & error_c0 & isReadReq(c0_tx_in.hdr.req_type);
  assign c1_enq_req = c1_tx_in.valid & error_c1 & isWriteReq(c1_tx_in.hdr.req_type) &
                      c1_tx_in.hdr.sop;
  assign c0_enq_en  = c0_enq_req & (~c0_full | c0_deq);
  assign c1_enq_en  = c1_enq_req & (~c1_full | c1_deq);

  assign c0_enq_entry = '{mdata: c0_tx_in.hdr.mdata, cl_len: c0_tx_in.hdr.cl_len,
                          vc_sel: c0_tx_in.hdr.vc_sel};
  assign c1_enq_entry = '{mdata: c1_tx_in.hdr.mdata, cl_len: c1_tx_in.hdr.cl_len,
                          vc_sel: c1_tx_in.hdr.vc_sel};

  mpf_vtp_err_rsp_fifo #(
    .T(t_mpf_vtp_err_rsp_c0_entry), .DEPTH(ERR_FIFO_DEPTH), .ALMFULL_SLOTS(ERR_ALMFULL_SLOTS)
  ) u_c0_fifo (
    .clk(clk), .reset_n(reset_n), .enq_data(c0_enq_entry), .enq_en(c0_enq_en),
    .deq_en(c0_deq), .first(c0_head), .notEmpty(c0_not_empty), .full(c0_full),
    .almostFull(c0_almfull)
  );

  mpf_vtp_err_rsp_fifo #(
    .T(t_mpf_vtp_err_rsp_c1_entry), .DEPTH(ERR_FIFO_DEPTH), .ALMFULL_SLOTS(ERR_ALMFULL_SLOTS)
  ) u_c1_fifo (
    .clk(clk), .reset_n(reset_n), .enq_data(c1_enq_entry), .enq_en(c1_enq_en),
    .deq_en(c1_deq), .first(c1_head), .notEmpty(c1_not_empty), .full(c1_full),
    .almostFull(c1_almfull)
  );

  assign err_almostFull = c0_almfull | c1_almfull;

  assign c0_slot_free = ~(c0_rx_in.rspValid | c0_rx_in.mmioRdValid | c0_rx_in.mmioWrValid);
  assign c1_slot_free = ~c1_rx_in.rspValid;
  assign c0_last      = (c0_beat == c0_head.cl_len);

  // The head descriptor stays queued until its last beat, so BURST always has one to emit;
  // a busy slot simply holds the beat counter.
  always_comb begin
    c0_state_nxt = c0_state;
    c0_beat_nxt  = c0_beat;
    c0_deq       = 1'b0;
    c0_inj_fire  = c0_slot_free & c0_not_empty;
    if (c0_inj_fire) begin
      c0_state_nxt = ERR_RSP_BURST;
      if (c0_last) begin
        c0_deq      = 1'b1;
        c0_beat_nxt = 2'd0;
      end else begin
        c0_beat_nxt = c0_beat + 2'd1;
      end
    end else if (!c0_not_empty) begin
      c0_state_nxt = ERR_RSP_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_state <= ERR_RSP_IDLE;
      c0_beat  <= 2'd0;
    end else begin
      c0_state <= c0_state_nxt;
      c0_beat  <= c0_beat_nxt;
    end
  end

  assign c1_inj_fire = c1_slot_free & c1_not_empty;
  assign c1_deq      = c1_inj_fire;

  always_comb begin
    c0_inj_rsp                = '0;
    c0_inj_rsp.hdr.vc_used    = c0_head.vc_sel;
    c0_inj_rsp.hdr.cl_num     = c0_beat;
    c0_inj_rsp.hdr.resp_type  = eRSP_RDLINE;
    c0_inj_rsp.hdr.mdata      = c0_head.mdata;
    c0_inj_rsp.data           = MPF_VTP_ERR_POISON_DATA;
    c0_inj_rsp.rspValid       = 1'b1;
    c1_inj_rsp                = '0;
    c1_inj_rsp.hdr.vc_used    = c1_head.vc_sel;
    c1_inj_rsp.hdr.format     = 1'b1;
    c1_inj_rsp.hdr.cl_num     = c1_head.cl_len;
    c1_inj_rsp.hdr.resp_type  = eRSP_WRLINE;
    c1_inj_rsp.hdr.mdata      = c1_head.mdata;
    c1_inj_rsp.rspValid       = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_rx_out    <= '0;
      c1_rx_out    <= '0;
      err_rsp_c0   <= 1'b0;
      err_rsp_c1   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      c0_rx_out  <= c0_inj_fire ? c0_inj_rsp : c0_rx_in;
      c1_rx_out  <= c1_inj_fire ? c1_inj_rsp : c1_rx_in;
      err_rsp_c0 <= c0_inj_fire;
      err_rsp_c1 <= c1_inj_fire;
      if ((c0_enq_req & ~c0_enq_en) | (c1_enq_req & ~c1_enq_en)) err_overflow <= 1'b1;
    end
  end

`ifdef MPF_VTP_ERR_RSP_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_err_c0 <= '0;
      stat_err_c1 <= '0;
    end else begin
      if (c0_enq_en && (stat_err_c0 != '1)) stat_err_c0 <= stat_err_c0 + 32'd1;
      if (c1_enq_en && (stat_err_c1 != '1)) stat_err_c1 <= stat_err_c1 + 32'd1;
    end
  end
`endif

endmodule
